// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode->execute pipeline register with load-use stall, flush, hold and bubble counter
// Ports: clk/rst (sync active-high); *_D decode-stage control word, register addresses and operands;
//        flush_i kills the instruction entering EX; hold_i freezes EX; *_E latched EX-stage copies;
//        stall_D tells decode/fetch to hold; bubble_cnt counts inserted bubbles (saturating).
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_D,
    input  logic              RegW_D,
    input  logic              MemW_D,
    input  logic              MemToReg_D,
    input  logic              ALUSrc_D,
    input  logic              ALUOp_D,
    input  logic [REG_AW-1:0] RA1_D,
    input  logic [REG_AW-1:0] RA2_D,
    input  logic [REG_AW-1:0] WA3_D,
    input  logic [DATA_W-1:0] RD1_D,
    input  logic [DATA_W-1:0] RD2_D,
    input  logic [DATA_W-1:0] ExtImm_D,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              valid_E,
    output logic              RegW_E,
    output logic              MemW_E,
    output logic              MemToReg_E,
    output logic              ALUSrc_E,
    output logic              ALUOp_E,
    output logic [REG_AW-1:0] WA3_E,
    output logic [DATA_W-1:0] RD1_E,
    output logic [DATA_W-1:0] RD2_E,
    output logic [DATA_W-1:0] ExtImm_E,
    output logic              stall_D,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              valid_q, valid_d;
    logic [4:0]        ctrl_q, ctrl_d;
    logic [REG_AW-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ra2_used, hazard, bubble, upd;

    assign ra2_used = ~ALUSrc_D | MemW_D;
    assign hazard   = valid_D & valid_q & ctrl_q[2] & ctrl_q[4] &
                      ((RA1_D == wa3_q) | (ra2_used & (RA2_D == wa3_q)));
    assign stall_D  = ~rst & ~flush_i & (hold_i | hazard);
    // hold outranks a hazard; flush outranks hold
    assign bubble   = flush_i | (~hold_i & hazard);
    assign upd      = flush_i | ~hold_i;

    always_comb begin
        valid_d = upd ? (valid_D & ~bubble) : valid_q;
        ctrl_d  = upd ? ((bubble | ~valid_D) ? 5'b0
                         : {RegW_D, MemW_D, MemToReg_D, ALUSrc_D, ALUOp_D}) : ctrl_q;
        wa3_d   = upd ? WA3_D : wa3_q;
        rd1_d   = upd ? RD1_D : rd1_q;
        rd2_d   = upd ? RD2_D : rd2_q;
        imm_d   = upd ? ExtImm_D : imm_q;
        cnt_d   = (bubble & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            wa3_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            wa3_q   <= wa3_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_E    = valid_q;
    assign RegW_E     = ctrl_q[4];
    assign MemW_E     = ctrl_q[3];
    assign MemToReg_E = ctrl_q[2];
    assign ALUSrc_E   = ctrl_q[1];
    assign ALUOp_E    = ctrl_q[0];
    assign WA3_E      = wa3_q;
    assign RD1_E      = rd1_q;
    assign RD2_E      = rd2_q;
    assign ExtImm_E   = imm_q;
    assign bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: table-driven check of the ID/EX register plus a saturation sequence on a 2-bit-counter copy
module tb_id_ex_pipe_reg;
    localparam logic O = 1'b1;
    localparam logic Z = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid_D, RegW_D, MemW_D, MemToReg_D, ALUSrc_D, ALUOp_D, flush_i, hold_i;
    logic [3:0]  RA1_D, RA2_D, WA3_D;
    logic [31:0] RD1_D, RD2_D, ExtImm_D;
    logic        valid_E, RegW_E, MemW_E, MemToReg_E, ALUSrc_E, ALUOp_E, stall_D;
    logic [3:0]  WA3_E;
    logic [31:0] RD1_E, RD2_E, ExtImm_E;
    logic [15:0] bubble_cnt;
    logic        s_valid_E, s_RegW_E, s_MemW_E, s_MemToReg_E, s_ALUSrc_E, s_ALUOp_E, s_stall_D;
    logic [3:0]  s_WA3_E;
    logic [31:0] s_RD1_E, s_RD2_E, s_ExtImm_E;
    logic [1:0]  s_bubble_cnt;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .valid_D(valid_D), .RegW_D(RegW_D), .MemW_D(MemW_D),
        .MemToReg_D(MemToReg_D), .ALUSrc_D(ALUSrc_D), .ALUOp_D(ALUOp_D),
        .RA1_D(RA1_D), .RA2_D(RA2_D), .WA3_D(WA3_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .ExtImm_D(ExtImm_D), .flush_i(flush_i), .hold_i(hold_i), .valid_E(valid_E),
        .RegW_E(RegW_E), .MemW_E(MemW_E), .MemToReg_E(MemToReg_E), .ALUSrc_E(ALUSrc_E),
        .ALUOp_E(ALUOp_E), .WA3_E(WA3_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .ExtImm_E(ExtImm_E), .stall_D(stall_D), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .valid_D(valid_D), .RegW_D(RegW_D), .MemW_D(MemW_D),
        .MemToReg_D(MemToReg_D), .ALUSrc_D(ALUSrc_D), .ALUOp_D(ALUOp_D),
        .RA1_D(RA1_D), .RA2_D(RA2_D), .WA3_D(WA3_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .ExtImm_D(ExtImm_D), .flush_i(flush_i), .hold_i(hold_i), .valid_E(s_valid_E),
        .RegW_E(s_RegW_E), .MemW_E(s_MemW_E), .MemToReg_E(s_MemToReg_E), .ALUSrc_E(s_ALUSrc_E),
        .ALUOp_E(s_ALUOp_E), .WA3_E(s_WA3_E), .RD1_E(s_RD1_E), .RD2_E(s_RD2_E),
        .ExtImm_E(s_ExtImm_E), .stall_D(s_stall_D), .bubble_cnt(s_bubble_cnt)
    );

    // cd/xc order: {RegW, MemW, MemToReg, ALUSrc, ALUOp}; xs is stall_D before the edge,
    // x* are E outputs after the edge; data fields compared only when chk=1
    typedef struct {
        logic        rst, fl, ho, vd;
        logic [4:0]  cd;
        logic [3:0]  ra1, ra2, wa3;
        logic [31:0] rd1, rd2, imm;
        logic        xs, xv;
        logic [4:0]  xc;
        logic [3:0]  xwa;
        logic [31:0] xr1, xr2, xim;
        logic [15:0] xcnt;
        logic        chk;
    } vec_t;

    vec_t vt[20];
    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; flush_i = v.fl; hold_i = v.ho; valid_D = v.vd;
        {RegW_D, MemW_D, MemToReg_D, ALUSrc_D, ALUOp_D} = v.cd;
        RA1_D = v.ra1; RA2_D = v.ra2; WA3_D = v.wa3;
        RD1_D = v.rd1; RD2_D = v.rd2; ExtImm_D = v.imm;
    endtask

    initial begin
        vec_t idle;
        idle = '{Z,Z,Z,Z,'0,'0,'0,'0,'0,'0,'0, Z,Z,'0,'0,'0,'0,'0,'0,Z};
        drive(idle);
        // T1 reset with junk inputs
        vt[0]  = '{O,Z,Z,O,5'b11111,4'd5,4'd5,4'd5,32'hA5A5A5A5,32'h5A5A5A5A,32'h12345678, Z,Z,'0,'0,'0,'0,'0,'0,O};
        vt[1]  = '{O,Z,O,O,5'b11111,4'd5,4'd5,4'd5,32'hDEADBEEF,32'hCAFEF00D,32'h87654321, Z,Z,'0,'0,'0,'0,'0,'0,O};
        // T2 DP pass-through
        vt[2]  = '{Z,Z,Z,O,5'b10001,4'd1,4'd2,4'd3,32'h11,32'h22,'0, Z,O,5'b10001,4'd3,32'h11,32'h22,'0,'0,O};
        // T3 LDRV then dependent ADD: one bubble, then ADD
        vt[3]  = '{Z,Z,Z,O,5'b10110,4'd0,4'd0,4'd5,32'h100,'0,32'h4, Z,O,5'b10110,4'd5,32'h100,'0,32'h4,'0,O};
        vt[4]  = '{Z,Z,Z,O,5'b10001,4'd5,4'd6,4'd7,32'hAA,32'hBB,'0, O,Z,'0,'0,'0,'0,'0,16'd1,Z};
        vt[5]  = '{Z,Z,Z,O,5'b10001,4'd5,4'd6,4'd7,32'hAA,32'hBB,'0, Z,O,5'b10001,4'd7,32'hAA,32'hBB,'0,16'd1,O};
        // LDRV then ADDI reading RA2=5 with ALUSrc=1: RA2 unused, no stall
        vt[6]  = '{Z,Z,Z,O,5'b10110,4'd0,4'd0,4'd5,32'h100,'0,32'h4, Z,O,5'b10110,4'd5,32'h100,'0,32'h4,16'd1,O};
        vt[7]  = '{Z,Z,Z,O,5'b10011,4'd1,4'd5,4'd8,32'h33,'0,32'h44, Z,O,5'b10011,4'd8,32'h33,'0,32'h44,16'd1,O};
        // LDRV then STRV whose RA2 (store data) matches: stall
        vt[8]  = '{Z,Z,Z,O,5'b10110,4'd0,4'd0,4'd9,32'h200,'0,32'h8, Z,O,5'b10110,4'd9,32'h200,'0,32'h8,16'd1,O};
        vt[9]  = '{Z,Z,Z,O,5'b01010,4'd2,4'd9,4'd0,32'h300,32'h55,32'hC, O,Z,'0,'0,'0,'0,'0,16'd2,Z};
        vt[10] = '{Z,Z,Z,O,5'b01010,4'd2,4'd9,4'd0,32'h300,32'h55,32'hC, Z,O,5'b01010,4'd0,32'h300,32'h55,32'hC,16'd2,O};
        // T4 flush beats hold, then hold freezes E for 3 cycles
        vt[11] = '{Z,O,O,O,5'b10001,4'd5,4'd5,4'd5,32'h1,32'h2,32'h3, Z,Z,'0,'0,'0,'0,'0,16'd3,Z};
        vt[12] = '{Z,Z,Z,O,5'b10001,4'd1,4'd2,4'd4,32'h66,32'h77,'0, Z,O,5'b10001,4'd4,32'h66,32'h77,'0,16'd3,O};
        for (int i = 13; i < 16; i++)
            vt[i] = '{Z,Z,O,O,5'b11111,4'd4,4'd4,4'd15,32'hDEADBEEF,32'hCAFEF00D,32'hFFFF, O,O,5'b10001,4'd4,32'h66,32'h77,'0,16'd3,O};
        // invalid decode slot: controls forced to 0
        vt[16] = '{Z,Z,Z,Z,5'b11111,4'd4,4'd4,4'd15,32'h1,32'h2,32'h3, Z,Z,'0,4'd15,32'h1,32'h2,32'h3,16'd3,O};
        // T6 reset during a load-use stall
        vt[17] = '{Z,Z,Z,O,5'b10110,4'd0,4'd0,4'd5,32'h100,'0,32'h4, Z,O,5'b10110,4'd5,32'h100,'0,32'h4,16'd3,O};
        vt[18] = '{O,Z,Z,O,5'b10001,4'd5,4'd6,4'd7,32'hAA,32'hBB,'0, Z,Z,'0,'0,'0,'0,'0,'0,O};
        vt[19] = '{Z,Z,Z,O,5'b10001,4'd5,4'd6,4'd7,32'hAA,32'hBB,'0, Z,O,5'b10001,4'd7,32'hAA,32'hBB,'0,'0,O};

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1 chk($sformatf("v%0d stall_D", i), 64'(stall_D), 64'(vt[i].xs));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid_E", i), 64'(valid_E), 64'(vt[i].xv));
            chk($sformatf("v%0d ctrl_E", i), 64'({RegW_E, MemW_E, MemToReg_E, ALUSrc_E, ALUOp_E}), 64'(vt[i].xc));
            chk($sformatf("v%0d bubble_cnt", i), 64'(bubble_cnt), 64'(vt[i].xcnt));
            if (vt[i].chk) begin
                chk($sformatf("v%0d WA3_E", i), 64'(WA3_E), 64'(vt[i].xwa));
                chk($sformatf("v%0d RD1_E", i), 64'(RD1_E), 64'(vt[i].xr1));
                chk($sformatf("v%0d RD2_E", i), 64'(RD2_E), 64'(vt[i].xr2));
                chk($sformatf("v%0d ExtImm_E", i), 64'(ExtImm_E), 64'(vt[i].xim));
            end
        end

        // T5 saturation of the 2-bit counter over 5 flushes
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("sat reset", 64'(s_bubble_cnt), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(idle);
            valid_D = 1'b1;
            flush_i = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("sat flush%0d cnt2", k), 64'(s_bubble_cnt), 64'(k > 3 ? 3 : k));
            chk($sformatf("sat flush%0d cnt16", k), 64'(bubble_cnt), 64'(k));
            chk($sformatf("sat flush%0d valid", k), 64'(s_valid_E), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
